// File: rtl/afe_buff_arbiter.sv
// afe_buff_arbiter: grants one access per cycle to the shared single-port AFE
// sample buffer, either a channel write or a read draining a channel toward
// the uDMA stream. Read data returns one cycle after the read and is decoupled
// through a 2-entry output FIFO with valid/ready handshaking.
// Optional feature macro: AFE_ARB_STARVE_PROT_EN enables the read-starvation
// counter. When it is undefined, writes have strict priority.
module afe_buff_arbiter #(
  parameter int NB_CH         = 4,
  parameter int AWIDTH        = 10,
  parameter int DWIDTH        = 32,
  parameter int RD_STARVE_LIM = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NB_CH-1:0]                wr_req_i,
  input  logic [NB_CH*DWIDTH-1:0]         wr_data_i,
  input  logic [NB_CH*AWIDTH-1:0]         wr_addr_i,
  output logic [NB_CH-1:0]                wr_ready_o,
  input  logic [NB_CH-1:0]                rd_valid_i,
  input  logic [NB_CH*AWIDTH-1:0]         rd_addr_i,
  output logic [NB_CH-1:0]                rd_ready_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [AWIDTH-1:0]               mem_addr_o,
  output logic [DWIDTH-1:0]               mem_wdata_o,
  input  logic [DWIDTH-1:0]               mem_rdata_i,
  output logic                            out_valid_o,
  output logic [DWIDTH-1:0]               out_data_o,
  output logic [((NB_CH > 1) ? $clog2(NB_CH) : 1)-1:0] out_ch_o,
  input  logic                            out_ready_i
);

  localparam int CW = (NB_CH > 1) ? $clog2(NB_CH) : 1;

  if (NB_CH < 1) begin : g_chk_nb_ch
    $error("afe_buff_arbiter: NB_CH must be at least 1");
  end
  if (RD_STARVE_LIM < 1) begin : g_chk_starve_lim
    $error("afe_buff_arbiter: RD_STARVE_LIM must be at least 1");
  end

  // Round-robin pick: first requester at or after ptr, modulo NB_CH.
  // Result MSB flags that some requester was found.
  function automatic logic [CW:0] rr_pick(input logic [NB_CH-1:0] req,
                                          input logic [CW-1:0]    ptr);
    logic [CW:0] res;
    int          k;
    res = '0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NB_CH;
      if (req[k]) res = {1'b1, CW'(k)};
    end
    return res;
  endfunction

  // Pointer after a grant to idx: the following channel, wrapping at NB_CH.
  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] idx);
    return (int'(idx) == NB_CH - 1) ? '0 : idx + 1'b1;
  endfunction

  logic [CW-1:0]     wr_rr, rd_rr;
  logic [CW:0]       wr_pick_p0, rd_pick_p0;
  logic [CW-1:0]     wr_idx_p0, rd_idx_p0;
  logic              gnt_wr_p0, gnt_rd_p0;
  logic              credit_p0;
  logic [NB_CH-1:0]  rd_elig_p0;

  // vld_p1 marks a read in flight; its data arrives on mem_rdata_i this cycle.
  logic              vld_p1;
  logic [CW-1:0]     rd_ch_p1;

  logic [1:0]        fifo_cnt;
  logic              fifo_wptr, fifo_rptr;
  logic [DWIDTH-1:0] fifo_data [2];
  logic [CW-1:0]     fifo_ch   [2];
  logic              fifo_push, fifo_pop;

`ifdef AFE_ARB_STARVE_PROT_EN
  localparam int SW = $clog2(RD_STARVE_LIM + 1);
  logic [SW-1:0]     streak;
`endif

  // A read may only issue while the FIFO plus the in-flight read leave room.
  assign credit_p0  = (fifo_cnt + {1'b0, vld_p1}) < 2'd2;
  assign rd_elig_p0 = rd_valid_i & {NB_CH{credit_p0}};

  assign fifo_push  = vld_p1;
  assign fifo_pop   = out_valid_o & out_ready_i;

  // Stage p0: arbitration and memory command, combinational from inputs and state.
  always_comb begin
    wr_pick_p0  = rr_pick(wr_req_i, wr_rr);
    rd_pick_p0  = rr_pick(rd_elig_p0, rd_rr);
    wr_idx_p0   = wr_pick_p0[CW-1:0];
    rd_idx_p0   = rd_pick_p0[CW-1:0];
`ifdef AFE_ARB_STARVE_PROT_EN
    gnt_rd_p0   = rst_ni & rd_pick_p0[CW] &
                  (~wr_pick_p0[CW] | (streak == SW'(RD_STARVE_LIM)));
`else
    gnt_rd_p0   = rst_ni & rd_pick_p0[CW] & ~wr_pick_p0[CW];
`endif
    gnt_wr_p0   = rst_ni & wr_pick_p0[CW] & ~gnt_rd_p0;

    wr_ready_o  = '0;
    rd_ready_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_wr_p0) begin
      wr_ready_o[wr_idx_p0] = 1'b1;
      mem_req_o             = 1'b1;
      mem_we_o              = 1'b1;
      mem_addr_o            = wr_addr_i[wr_idx_p0*AWIDTH +: AWIDTH];
      mem_wdata_o           = wr_data_i[wr_idx_p0*DWIDTH +: DWIDTH];
    end else if (gnt_rd_p0) begin
      rd_ready_o[rd_idx_p0] = 1'b1;
      mem_req_o             = 1'b1;
      mem_addr_o            = rd_addr_i[rd_idx_p0*AWIDTH +: AWIDTH];
    end
  end

  // Control state: round-robin pointers, read-in-flight flag, FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_rr     <= '0;
      rd_rr     <= '0;
      vld_p1    <= 1'b0;
      fifo_cnt  <= '0;
      fifo_wptr <= 1'b0;
      fifo_rptr <= 1'b0;
    end else begin
      if (gnt_wr_p0) wr_rr <= rr_next(wr_idx_p0);
      if (gnt_rd_p0) rd_rr <= rr_next(rd_idx_p0);
      vld_p1 <= gnt_rd_p0;
      if (fifo_push) fifo_wptr <= ~fifo_wptr;
      if (fifo_pop)  fifo_rptr <= ~fifo_rptr;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef AFE_ARB_STARVE_PROT_EN
  // Count write grants that bypass an eligible read; cleared by a read or idle read side.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      streak <= '0;
    end else if (gnt_rd_p0 || !rd_pick_p0[CW]) begin
      streak <= '0;
    end else if (gnt_wr_p0) begin
      streak <= streak + 1'b1;
    end
  end
`endif

  // Stage p1: capture read channel id; the returning sample lands in the FIFO.
  always_ff @(posedge clk_i) begin
    if (gnt_rd_p0) rd_ch_p1 <= rd_idx_p0;
    if (fifo_push) begin
      fifo_data[fifo_wptr] <= mem_rdata_i;
      fifo_ch[fifo_wptr]   <= rd_ch_p1;
    end
  end

  // Head data is masked while empty so the stream outputs read zero after reset.
  assign out_valid_o = (fifo_cnt != 2'd0);
  assign out_data_o  = out_valid_o ? fifo_data[fifo_rptr] : '0;
  assign out_ch_o    = out_valid_o ? fifo_ch[fifo_rptr]   : '0;

endmodule
